// File: rtl/stats_pkg.sv
// Shared encodings and helpers for the statistics counter bank.
package stats_pkg;

  // Field selector for the shadow read port.
  typedef enum logic [1:0] {
    SEL_PKT  = 2'd0,
    SEL_BYTE = 2'd1,
    SEL_OVF  = 2'd2,
    SEL_RSVD = 2'd3
  } rd_sel_e;

  // Width of a channel index; never narrower than one bit so a
  // single-channel bank still has a legal clr_ch port.
  function automatic int ch_idx_w(input int num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/stats_channel.sv
// One channel of live statistics: packet and byte counters with
// saturating or wrapping arithmetic and sticky overflow flags.
module stats_channel
  import stats_pkg::*;
#(
  parameter int CNT_W    = 48,
  parameter int BYTES_W  = 16,
  parameter bit SATURATE = 1'b1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               inc,
  input  logic               clr,
  input  logic [BYTES_W-1:0] bytes,
  output logic [CNT_W-1:0]   pkt_cnt,
  output logic [CNT_W-1:0]   byte_cnt,
  output logic               pkt_ovf,
  output logic               byte_ovf
);

  localparam int SUM_W = CNT_W + 1;

  logic [CNT_W-1:0] pkt_cnt_reg, pkt_cnt_next;
  logic [CNT_W-1:0] byte_cnt_reg, byte_cnt_next;
  logic             pkt_ovf_reg, pkt_ovf_next;
  logic             byte_ovf_reg, byte_ovf_next;

  // A clear zeroes the base the increment is applied to, so a clear and
  // an event in the same cycle leave exactly that event counted.
  logic [CNT_W-1:0] pkt_base, byte_base;
  logic             pkt_ovf_base, byte_ovf_base;
  logic [CNT_W:0]   pkt_sum, byte_sum;

  // Next-state: clear first, then add, then saturate or wrap on carry-out.
  always_comb begin
    pkt_base      = clr ? '0 : pkt_cnt_reg;
    byte_base     = clr ? '0 : byte_cnt_reg;
    pkt_ovf_base  = clr ? 1'b0 : pkt_ovf_reg;
    byte_ovf_base = clr ? 1'b0 : byte_ovf_reg;

    pkt_sum  = {1'b0, pkt_base} + SUM_W'(1);
    byte_sum = {1'b0, byte_base} + SUM_W'(bytes);

    pkt_cnt_next  = pkt_base;
    byte_cnt_next = byte_base;
    pkt_ovf_next  = pkt_ovf_base;
    byte_ovf_next = byte_ovf_base;

    if (inc) begin
      pkt_ovf_next  = pkt_ovf_base | pkt_sum[CNT_W];
      byte_ovf_next = byte_ovf_base | byte_sum[CNT_W];
      if (SATURATE && pkt_sum[CNT_W]) begin
        pkt_cnt_next = '1;
      end else begin
        pkt_cnt_next = pkt_sum[CNT_W-1:0];
      end
      if (SATURATE && byte_sum[CNT_W]) begin
        byte_cnt_next = '1;
      end else begin
        byte_cnt_next = byte_sum[CNT_W-1:0];
      end
    end
  end

  // Live counter and flag registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pkt_cnt_reg  <= '0;
      byte_cnt_reg <= '0;
      pkt_ovf_reg  <= 1'b0;
      byte_ovf_reg <= 1'b0;
    end else begin
      pkt_cnt_reg  <= pkt_cnt_next;
      byte_cnt_reg <= byte_cnt_next;
      pkt_ovf_reg  <= pkt_ovf_next;
      byte_ovf_reg <= byte_ovf_next;
    end
  end

  assign pkt_cnt  = pkt_cnt_reg;
  assign byte_cnt = byte_cnt_reg;
  assign pkt_ovf  = pkt_ovf_reg;
  assign byte_ovf = byte_ovf_reg;

endmodule

// File: rtl/stats_counter_bank.sv
// Multi-channel packet/byte statistics with atomic snapshot into shadow
// registers and a single read port that only ever returns shadow values.
module stats_counter_bank
  import stats_pkg::*;
#(
  parameter int  NUM_CH   = 4,
  parameter int  CNT_W    = 48,
  parameter int  BYTES_W  = 16,
  parameter bit  SATURATE = 1'b1,
  localparam int CH_W     = ch_idx_w(NUM_CH)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NUM_CH-1:0]         pkt_valid,
  input  logic [NUM_CH*BYTES_W-1:0] pkt_bytes,
  input  logic                      clr_valid,
  input  logic                      clr_all,
  input  logic [CH_W-1:0]           clr_ch,
  input  logic                      snap,
  input  logic                      rd_en,
  input  logic [3:0]                rd_ch,
  input  logic [1:0]                rd_sel,
  output logic                      rd_valid,
  output logic [CNT_W-1:0]          rd_data,
  output logic                      rd_err,
  output logic                      ovf_any
);

  logic [CNT_W-1:0]  live_pkt  [NUM_CH];
  logic [CNT_W-1:0]  live_byte [NUM_CH];
  logic [NUM_CH-1:0] live_pkt_ovf;
  logic [NUM_CH-1:0] live_byte_ovf;
  logic [NUM_CH-1:0] clr_vec;

  logic [CNT_W-1:0]  shadow_pkt_reg  [NUM_CH];
  logic [CNT_W-1:0]  shadow_byte_reg [NUM_CH];
  logic [NUM_CH-1:0] shadow_pkt_ovf_reg;
  logic [NUM_CH-1:0] shadow_byte_ovf_reg;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      // Clear decode: an out-of-range clr_ch matches no channel, so it is a no-op.
      assign clr_vec[gi] = clr_valid & (clr_all | (32'(clr_ch) == gi));

      stats_channel #(
        .CNT_W    (CNT_W),
        .BYTES_W  (BYTES_W),
        .SATURATE (SATURATE)
      ) u_ch (
        .clk      (clk),
        .rstn     (rstn),
        .inc      (pkt_valid[gi]),
        .clr      (clr_vec[gi]),
        .bytes    (pkt_bytes[gi*BYTES_W +: BYTES_W]),
        .pkt_cnt  (live_pkt[gi]),
        .byte_cnt (live_byte[gi]),
        .pkt_ovf  (live_pkt_ovf[gi]),
        .byte_ovf (live_byte_ovf[gi])
      );

      // Shadow capture uses the live register values, i.e. the state before
      // this cycle's increments and clears take effect.
      always_ff @(posedge clk) begin
        if (!rstn) begin
          shadow_pkt_reg[gi]      <= '0;
          shadow_byte_reg[gi]     <= '0;
          shadow_pkt_ovf_reg[gi]  <= 1'b0;
          shadow_byte_ovf_reg[gi] <= 1'b0;
        end else if (snap) begin
          shadow_pkt_reg[gi]      <= live_pkt[gi];
          shadow_byte_reg[gi]     <= live_byte[gi];
          shadow_pkt_ovf_reg[gi]  <= live_pkt_ovf[gi];
          shadow_byte_ovf_reg[gi] <= live_byte_ovf[gi];
        end
      end
    end
  endgenerate

  logic [CNT_W-1:0] sel_pkt, sel_byte;
  logic             sel_pkt_ovf, sel_byte_ovf;
  logic             rd_err_next;
  logic [CNT_W-1:0] rd_data_next;

  // Read mux: pick the addressed shadow channel, then the requested field.
  always_comb begin
    sel_pkt      = '0;
    sel_byte     = '0;
    sel_pkt_ovf  = 1'b0;
    sel_byte_ovf = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (32'(rd_ch) == c) begin
        sel_pkt      = shadow_pkt_reg[c];
        sel_byte     = shadow_byte_reg[c];
        sel_pkt_ovf  = shadow_pkt_ovf_reg[c];
        sel_byte_ovf = shadow_byte_ovf_reg[c];
      end
    end

    rd_err_next  = (32'(rd_ch) >= NUM_CH) || (rd_sel == SEL_RSVD);
    rd_data_next = '0;
    if (!rd_err_next) begin
      case (rd_sel)
        SEL_PKT:  rd_data_next = sel_pkt;
        SEL_BYTE: rd_data_next = sel_byte;
        SEL_OVF:  rd_data_next = CNT_W'({sel_byte_ovf, sel_pkt_ovf});
        default:  rd_data_next = '0;
      endcase
    end
  end

  logic             rd_valid_reg;
  logic [CNT_W-1:0] rd_data_reg;
  logic             rd_err_reg;
  logic             ovf_any_reg;

  // Registered read response; data is held between reads.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_valid_reg <= 1'b0;
      rd_data_reg  <= '0;
      rd_err_reg   <= 1'b0;
    end else begin
      rd_valid_reg <= rd_en;
      rd_err_reg   <= rd_en & rd_err_next;
      if (rd_en) begin
        rd_data_reg <= rd_data_next;
      end
    end
  end

  // Registered reduction of every live sticky flag.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ovf_any_reg <= 1'b0;
    end else begin
      ovf_any_reg <= (|live_pkt_ovf) | (|live_byte_ovf);
    end
  end

  assign rd_valid = rd_valid_reg;
  assign rd_data  = rd_data_reg;
  assign rd_err   = rd_err_reg;
  assign ovf_any  = ovf_any_reg;

endmodule
